// File: rtl/sram_rd_arb_if.sv
// Bus bundle between the compute requesters, the loader write stream and one
// 1W1R SRAM. The arbiter takes the slave view; the surrounding logic (or a
// bench standing in for it) takes the master view.
interface sram_rd_arb_if #(
    parameter int WWORD = 32,
    parameter int WADDR = 5,
    parameter int NREQ  = 4
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WADDR-1:0] req_addr;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WWORD-1:0]      rsp_data;
    logic                  wr_valid;
    logic [WADDR-1:0]      wr_addr;
    logic [WWORD-1:0]      wr_data;
    logic                  wr_ready;
    logic                  err_oor;
    logic                  sram_cena;
    logic [WADDR-1:0]      sram_aa;
    logic [WWORD-1:0]      sram_qa;
    logic                  sram_cenb;
    logic [WADDR-1:0]      sram_ab;
    logic [WWORD-1:0]      sram_db;

    modport slave (
        input  req_valid, req_addr, wr_valid, wr_addr, wr_data, sram_qa,
        output req_ready, rsp_valid, rsp_data, wr_ready, err_oor,
               sram_cena, sram_aa, sram_cenb, sram_ab, sram_db
    );

    modport master (
        output req_valid, req_addr, wr_valid, wr_addr, wr_data, sram_qa,
        input  req_ready, rsp_valid, rsp_data, wr_ready, err_oor,
               sram_cena, sram_aa, sram_cenb, sram_ab, sram_db
    );
endinterface

// File: rtl/sram_rd_arb.sv
// Round-robin read-port arbiter and registered write sequencer for one
// bhv_1w1r_sram. Read data returns two cycles after the grant, tagged one-hot
// with the requester that asked for it.
module sram_rd_arb #(
    parameter int WWORD = 32,
    parameter int WADDR = 5,
    parameter int DEPTH = 24,
    parameter int NREQ  = 4
) (
    input  logic         clk,
    input  logic         rstn,
    sram_rd_arb_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam logic [WADDR:0] DEPTH_W = (WADDR + 1)'(DEPTH);

    typedef logic [PW-1:0]   ptr_t;
    typedef logic [NREQ-1:0] vec_t;

    ptr_t             ptr;
    ptr_t             ptr_nxt;
    ptr_t             win;
    ptr_t             cand;
    logic             found;
    logic             collide;
    logic             grant;
    logic             rd_oor;
    logic             wr_oor;
    logic             wr_go;
    logic [WADDR-1:0] win_addr;
    vec_t             win_oh;
    vec_t             ready;
    vec_t             tag_rd;
    vec_t             tag_rsp;
    logic             cena_q;
    logic [WADDR-1:0] aa_q;
    logic             cenb_q;
    logic [WADDR-1:0] ab_q;
    logic [WWORD-1:0] db_q;
    logic             err_q;

    // Pick the first valid requester at or after ptr; withhold the grant in
    // reset and when the same-cycle write targets the winner's address, so the
    // read is re-granted next cycle and sees the freshly written word.
    always_comb begin
        // NOTE: every signal this block drives gets a default first, so no path can infer a latch.
        found    = 1'b0;
        win      = '0;
        cand     = '0;
        win_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr_t'((int'(ptr) + k) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (win == ptr_t'(k)) begin
                win_addr = bus.req_addr[k*WADDR +: WADDR];
            end
        end
        collide = bus.wr_valid && (win_addr == bus.wr_addr);
        grant   = rstn && found && !collide;
        win_oh  = vec_t'(1) << win;
        ready   = grant ? win_oh : '0;
        ptr_nxt = ptr;
        if (grant) begin
            ptr_nxt = (win == ptr_t'(NREQ - 1)) ? '0 : win + ptr_t'(1);
        end
        rd_oor = {1'b0, win_addr} >= DEPTH_W;
        wr_oor = {1'b0, bus.wr_addr} >= DEPTH_W;
        wr_go  = bus.wr_valid && !wr_oor;
    end

    // Read issue: one-cycle SRAM enable plus a two-stage tag pipeline that
    // lines rsp_valid up with the SRAM's registered output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr     <= '0;
            cena_q  <= 1'b1;
            aa_q    <= '0;
            tag_rd  <= '0;
            tag_rsp <= '0;
        end else begin
            // NOTE: state is updated with <= so every flop samples pre-edge values, like real hardware.
            ptr     <= ptr_nxt;
            cena_q  <= !grant;
            tag_rd  <= ready;
            tag_rsp <= tag_rd;
            if (grant) begin
                aa_q <= win_addr;
            end
        end
    end

    // Write issue: register in-range writes onto the write port for one
    // cycle; out-of-range writes are dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cenb_q <= 1'b1;
            ab_q   <= '0;
            db_q   <= '0;
        end else begin
            cenb_q <= !wr_go;
            if (wr_go) begin
                ab_q <= bus.wr_addr;
                db_q <= bus.wr_data;
            end
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if ((grant && rd_oor) || (bus.wr_valid && wr_oor)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = tag_rsp;
    assign bus.rsp_data  = bus.sram_qa;
    assign bus.wr_ready  = rstn;
    assign bus.err_oor   = err_q;
    assign bus.sram_cena = cena_q;
    assign bus.sram_aa   = aa_q;
    assign bus.sram_cenb = cenb_q;
    assign bus.sram_ab   = ab_q;
    assign bus.sram_db   = db_q;
endmodule

// File: tb/tb_sram_rd_arb.sv
// Directed bench for sram_rd_arb: a per-cycle vector table for the main
// traffic patterns, plus hand-written sequences for pointer behaviour and
// mid-operation reset. A behavioural 1W1R SRAM sits on the memory side.
module tb_sram_rd_arb;
    localparam int WWORD = 32;
    localparam int WADDR = 5;
    localparam int DEPTH = 24;
    localparam int NREQ  = 4;
    localparam int NV    = 21;

    localparam logic [19:0] A0123 = {5'd3, 5'd2, 5'd1, 5'd0};

    typedef struct {
        logic [3:0]  rv;
        logic [19:0] ra;
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  e_rdy;
        logic [3:0]  e_rsp;
        logic        e_chk;
        logic [31:0] e_data;
        logic        e_cenb;
        logic        e_err;
    } vrec_t;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_bad;
    int   n_grant;
    vrec_t tbl [NV];
    logic [31:0] mem [32];

    sram_rd_arb_if #(.WWORD(WWORD), .WADDR(WADDR), .NREQ(NREQ)) bus ();

    sram_rd_arb #(.WWORD(WWORD), .WADDR(WADDR), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: registered read, write lands on the same edge (read sees old data).
    always @(posedge clk) begin
        if (!bus.sram_cena) bus.sram_qa <= mem[bus.sram_aa];
        if (!bus.sram_cenb) mem[bus.sram_ab] <= bus.sram_db;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vrec_t mk(input logic [3:0] rv, input logic [19:0] ra, input logic wv,
                                 input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] rdy,
                                 input logic [3:0] rsp, input logic chk, input logic [31:0] dat,
                                 input logic cenb, input logic err);
        vrec_t r;
        r.rv = rv; r.ra = ra; r.wv = wv; r.wa = wa; r.wd = wd;
        r.e_rdy = rdy; r.e_rsp = rsp; r.e_chk = chk; r.e_data = dat;
        r.e_cenb = cenb; r.e_err = err;
        return r;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn  = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;

        // preload writes, then all four requesters continuously valid
        tbl[0]  = mk(4'b0000, 20'd0, 1'b1, 5'd0, 32'hA0, 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b1, 1'b0);
        tbl[1]  = mk(4'b0000, 20'd0, 1'b1, 5'd1, 32'hA1, 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
        tbl[2]  = mk(4'b0000, 20'd0, 1'b1, 5'd2, 32'hA2, 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
        tbl[3]  = mk(4'b0000, 20'd0, 1'b1, 5'd3, 32'hA3, 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
        tbl[4]  = mk(4'b1111, A0123, 1'b0, 5'd0, 32'h0,  4'b0001, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
        tbl[5]  = mk(4'b1111, A0123, 1'b0, 5'd0, 32'h0,  4'b0010, 4'b0000, 1'b0, 32'h0, 1'b1, 1'b0);
        tbl[6]  = mk(4'b1111, A0123, 1'b0, 5'd0, 32'h0,  4'b0100, 4'b0001, 1'b1, 32'hA0, 1'b1, 1'b0);
        tbl[7]  = mk(4'b1111, A0123, 1'b0, 5'd0, 32'h0,  4'b1000, 4'b0010, 1'b1, 32'hA1, 1'b1, 1'b0);
        tbl[8]  = mk(4'b1111, A0123, 1'b0, 5'd0, 32'h0,  4'b0001, 4'b0100, 1'b1, 32'hA2, 1'b1, 1'b0);
        tbl[9]  = mk(4'b0000, 20'd0, 1'b0, 5'd0, 32'h0,  4'b0000, 4'b1000, 1'b1, 32'hA3, 1'b1, 1'b0);
        // collision: req1 reads addr 7 while addr 7 is written
        tbl[10] = mk(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, 1'b1, 5'd7, 32'h55, 4'b0000, 4'b0001, 1'b1, 32'hA0, 1'b1, 1'b0);
        tbl[11] = mk(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, 1'b0, 5'd0, 32'h0,  4'b0010, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
        tbl[12] = mk(4'b0000, 20'd0, 1'b0, 5'd0, 32'h0,  4'b0000, 4'b0000, 1'b0, 32'h0, 1'b1, 1'b0);
        // write addr 3, read it back the next cycle
        tbl[13] = mk(4'b0000, 20'd0, 1'b1, 5'd3, 32'h1234, 4'b0000, 4'b0010, 1'b1, 32'h55, 1'b1, 1'b0);
        tbl[14] = mk(4'b0100, {5'd0, 5'd3, 5'd0, 5'd0}, 1'b0, 5'd0, 32'h0, 4'b0100, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
        tbl[15] = mk(4'b0000, 20'd0, 1'b0, 5'd0, 32'h0,  4'b0000, 4'b0000, 1'b0, 32'h0, 1'b1, 1'b0);
        // out-of-range read, then out-of-range write
        tbl[16] = mk(4'b1000, {5'd25, 15'd0}, 1'b0, 5'd0, 32'h0, 4'b1000, 4'b0100, 1'b1, 32'h1234, 1'b1, 1'b0);
        tbl[17] = mk(4'b0000, 20'd0, 1'b0, 5'd0, 32'h0,  4'b0000, 4'b0000, 1'b0, 32'h0, 1'b1, 1'b1);
        tbl[18] = mk(4'b0000, 20'd0, 1'b1, 5'd30, 32'hDEAD, 4'b0000, 4'b1000, 1'b0, 32'h0, 1'b1, 1'b1);
        tbl[19] = mk(4'b0000, 20'd0, 1'b0, 5'd0, 32'h0,  4'b0000, 4'b0000, 1'b0, 32'h0, 1'b1, 1'b1);
        tbl[20] = mk(4'b0000, 20'd0, 1'b0, 5'd0, 32'h0,  4'b0000, 4'b0000, 1'b0, 32'h0, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(bus.req_ready), 32'h0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset sram_cena", 32'(bus.sram_cena), 32'h1);
        check("reset sram_cenb", 32'(bus.sram_cenb), 32'h1);
        check("reset err_oor", 32'(bus.err_oor), 32'h0);
        check("reset wr_ready", 32'(bus.wr_ready), 32'h0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            bus.req_valid = tbl[i].rv;
            bus.req_addr  = tbl[i].ra;
            bus.wr_valid  = tbl[i].wv;
            bus.wr_addr   = tbl[i].wa;
            bus.wr_data   = tbl[i].wd;
            @(negedge clk);
            check($sformatf("row%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rdy));
            check($sformatf("row%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].e_rsp));
            if (tbl[i].e_chk) begin
                check($sformatf("row%0d rsp_data", i), bus.rsp_data, tbl[i].e_data);
            end
            check($sformatf("row%0d sram_cenb", i), 32'(bus.sram_cenb), 32'(tbl[i].e_cenb));
            check($sformatf("row%0d err_oor", i), 32'(bus.err_oor), 32'(tbl[i].e_err));
            @(posedge clk);
            #1;
        end

        // only requester 2 valid for five cycles
        n_grant = 0;
        for (int c = 0; c < 5; c++) begin
            bus.req_valid = 4'b0100;
            bus.req_addr  = {5'd0, 5'd2, 5'd0, 5'd0};
            @(negedge clk);
            check($sformatf("solo2 c%0d req_ready", c), 32'(bus.req_ready), 32'h4);
            if (bus.req_ready == 4'b0100) n_grant++;
            @(posedge clk);
            #1;
        end
        check("solo2 grant count", 32'(n_grant), 32'd5);

        // requesters 1 and 3 together: pointer sits at 3
        bus.req_valid = 4'b1010;
        bus.req_addr  = {5'd3, 5'd0, 5'd1, 5'd0};
        @(negedge clk);
        check("ptr3 req_ready", 32'(bus.req_ready), 32'h8);
        check("solo2 rsp_valid", 32'(bus.rsp_valid), 32'h4);
        check("solo2 rsp_data", bus.rsp_data, 32'hA2);
        @(posedge clk);
        #1;

        // reset one cycle after the grant to requester 3
        rstn = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_addr  = A0123;
        #1;
        check("async req_ready", 32'(bus.req_ready), 32'h0);
        check("async rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("async sram_cena", 32'(bus.sram_cena), 32'h1);
        check("async sram_cenb", 32'(bus.sram_cenb), 32'h1);
        check("async sram_aa", 32'(bus.sram_aa), 32'h0);
        check("async sram_ab", 32'(bus.sram_ab), 32'h0);
        check("async sram_db", bus.sram_db, 32'h0);
        check("async err_oor", 32'(bus.err_oor), 32'h0);
        check("async wr_ready", 32'(bus.wr_ready), 32'h0);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("post-reset c%0d rsp_valid", c), 32'(bus.rsp_valid), 32'h0);
        end

        // pointer back at 0, out-of-range write dropped and flagged
        @(posedge clk);
        #1;
        bus.req_valid = 4'b1111;
        bus.req_addr  = A0123;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 5'd30;
        bus.wr_data   = 32'hBEEF;
        @(negedge clk);
        check("post-reset req_ready", 32'(bus.req_ready), 32'h1);
        check("post-reset wr_ready", 32'(bus.wr_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 4'b0000;
        bus.wr_valid  = 1'b0;
        @(negedge clk);
        check("oor write sram_cenb", 32'(bus.sram_cenb), 32'h1);
        check("oor write err_oor", 32'(bus.err_oor), 32'h1);
        check("read after reset sram_cena", 32'(bus.sram_cena), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_rd_arb.md
# sram_rd_arb

Round-robin read-port arbiter and write sequencer for one `bhv_1w1r_sram` instance in the CNN buffer hierarchy (weight/feature line buffers). Up to NREQ compute-side requesters share the single SRAM read port through valid/ready handshakes. Read data returns with a one-hot response tag. A single loader-side write stream is registered onto the write port, with depth checking and read-after-write collision protection.

## Interface
- `WWORD`, 32: data word width.
- `WADDR`, 5: address width.
- `DEPTH`, 24: valid words; addresses ≥ DEPTH are out of range.
- `NREQ`, 4: number of read requesters, 2..8.

Ports:
- `clk` in 1: single clock; the SRAM's clka and clkb both tie to it.
- `rstn` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: read request per requester.
- `req_addr` in NREQ*WADDR: requester i's address at bits [i*WADDR +: WADDR].
- `req_ready` out NREQ: grant; handshake when valid & ready.
- `rsp_valid` out NREQ: one-hot; read data for requester i is on `rsp_data`.
- `rsp_data` out WWORD: passthrough of `sram_qa`.
- `wr_valid` in 1: write request.
- `wr_addr` in WADDR: write address.
- `wr_data` in WWORD: write data.
- `wr_ready` out 1: tied 1 outside reset; writes are never stalled.
- `err_oor` out 1: sticky; set by any out-of-range read or write.
- `sram_cena` out 1: active-low read enable.
- `sram_aa` out WADDR: read address.
- `sram_qa` in WWORD: SRAM read data.
- `sram_cenb` out 1: active-low write enable.
- `sram_ab` out WADDR: write address.
- `sram_db` out WWORD: write data.

## Operation
- **Arbitration:** round-robin pointer `ptr` (reset 0). Winner is the first i with `req_valid[i]`, searching ptr, ptr+1, … mod NREQ.
  - `req_ready` is one-hot on the winner, and all-zero if no valid or a collision block applies.
  - `req_ready` depends combinationally on `req_valid`.
  - Requesters hold valid and addr stable until ready.
- **Pointer update:** on a read handshake by i, `ptr` ← (i+1) mod NREQ. No handshake leaves `ptr` unchanged.
- **Read issue:** at the handshake edge, register `sram_cena`=0 and `sram_aa`=addr for exactly one cycle, plus a tag = one-hot i. The SRAM samples on the next edge; the tag advances one more stage and drives `rsp_valid`.
- **Out-of-range read (addr ≥ DEPTH):** still granted and still returns a response (data undefined). Sets `err_oor`.
- **Write:** on `wr_valid`, register `sram_cenb`=0, `sram_ab`, `sram_db` for one cycle.
  - If `wr_addr` ≥ DEPTH, `sram_cenb` stays 1 (write dropped) and `err_oor` is set.
- **Collision block:** if `wr_valid` is high in the same cycle and the winner's address equals `wr_addr`, no read grant that cycle and `ptr` holds. The read is granted the next cycle (if no new collision), so it observes the new data.
- **Responses:** no backpressure; requesters must accept `rsp_valid` unconditionally.
- **`err_oor`:** cleared only by reset.

## Timing
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `sram_cena`=1, `sram_cenb`=1, `sram_aa`=0, `sram_ab`=0, `sram_db`=0, `err_oor`=0, `wr_ready`=0, `ptr`=0.
- **Read latency:** handshake at edge E0 → `sram_cena` low during E0..E1 → `rsp_valid` high during E1..E2, with data valid for the whole cycle (SRAM output delay < 1 cycle).
- **Throughput:** one read per cycle, back-to-back; `sram_cena` stays low continuously.
- **Write latency:** accept at E0 → memory updated at E1.
- A read accepted at E0+1 or later returns data written by a write accepted at E0.
- **Simultaneous events:** a non-colliding read and write in the same cycle both proceed.
- **Reset mid-operation:** in-flight tags are discarded, no spurious `rsp_valid` after reset release, and pending writes are cancelled.

## Test plan
- **All four requesters continuously valid**, addrs 0,1,2,3 preloaded with 0xA0..0xA3 → grants 0,1,2,3,0,… one per cycle. `rsp_valid` 0001,0010,0100,1000 with data 0xA0..0xA3, each 2 cycles after its grant.
- **Write 0x55 to addr 7 while the winner reads addr 7 in the same cycle** → no grant that cycle. Grant next cycle; response data = 0x55.
- **Write then read back-to-back:** write addr 3 = 0x1234 at E0, read addr 3 accepted at E1 → `rsp_data`=0x1234 at E2..E3.
- **Write addr 30 (≥24)** → `sram_cenb` stays 1 and `err_oor`=1. **Read addr 25** → granted, response returned, `err_oor` stays 1 until reset.
- **Only requester 2 valid for 5 cycles** → 5 consecutive grants to 2. `ptr`=3 afterwards; then req 1 and 3 valid together → 3 granted first.
- **Assert `rstn` low one cycle after a grant** → `rsp_valid` never asserts for that read. All outputs return to reset values immediately (asynchronously).
